// File: rtl/ip_hdr_stats_delay.sv
// Packet header statistics stage with a short FWFT delay FIFO.
// Beats pass through a small buffer. On the first beat of each packet (the head
// beat) the stage latches a header field and the folded IP checksum, and it bumps
// one counter for each source port flagged in TUSER.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | waiting for the head beat of the next packet
// PAYLOAD | head beat seen, passing beats until TLAST
module ip_hdr_stats_delay #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS    = 2,
    parameter int NUM_PORTS          = 8,
    parameter int SRC_PORT_POS       = 16,
    parameter int CNT_WIDTH          = 32,
    parameter int CAP_LSB            = 240,
    parameter int CAP_WIDTH          = 16
) (
    input  logic                                AXI_ACLK,
    input  logic                                reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]        S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]      S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]       S_AXIS_TUSER,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]        M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]      M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]       M_AXIS_TUSER,
    output logic                                M_AXIS_TLAST,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    input  logic [31:0]                         checksum_in,
    input  logic [NUM_PORTS-1:0]                cnt_clear,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]      port_count,
    output logic [15:0]                         checksum_out,
    output logic [CAP_WIDTH-1:0]                cap_field,
    output logic                                cap_valid
);
    localparam int DEPTH   = 2**FIFO_DEPTH_BITS;
    localparam int STRB_W  = C_AXIS_DATA_WIDTH/8;
    localparam int ENTRY_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
    // Ready drops one entry early so an upstream beat already in flight still fits.
    localparam logic [FIFO_DEPTH_BITS:0] NEAR_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH-1);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    logic [ENTRY_W-1:0]         mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic                       wr_en, rd_en, head_beat;
    state_t                     state, state_next;
    logic [CNT_WIDTH-1:0]       cnt [NUM_PORTS];
    logic [16:0]                sum1;
    logic [15:0]                sum2;

    assign S_AXIS_TREADY = (count < NEAR_FULL);
    assign M_AXIS_TVALID = (count != '0);
    assign wr_en = S_AXIS_TVALID & S_AXIS_TREADY;
    assign rd_en = M_AXIS_TVALID & M_AXIS_TREADY;
    assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = mem[rd_ptr];

    // Storage array; the head entry is read combinationally (first-word fall-through).
    always_ff @(posedge AXI_ACLK) begin
        if (wr_en && !reset)
            mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    end

    // Pointers and occupancy; a simultaneous read and write leaves the count unchanged.
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (rd_en) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (FIFO_DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet state register.
    always_ff @(posedge AXI_ACLK) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and head-beat detection from output handshakes.
    always_comb begin
        state_next = state;
        head_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en) begin
                    head_beat = 1'b1;
                    if (!M_AXIS_TLAST) state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rd_en && M_AXIS_TLAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // End-around-carry fold; the 17-bit first sum cannot carry again after one fold.
    always_comb begin
        sum1 = {1'b0, checksum_in[15:0]} + {1'b0, checksum_in[31:16]};
        sum2 = sum1[15:0] + {15'd0, sum1[16]};
    end

    // Header captures, held between head beats.
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            checksum_out <= '0;
            cap_field    <= '0;
            cap_valid    <= 1'b0;
        end else begin
            cap_valid <= head_beat;
            if (head_beat) begin
                checksum_out <= ~sum2;
                cap_field    <= M_AXIS_TDATA[CAP_LSB +: CAP_WIDTH];
            end
        end
    end

    // Saturating per-port counters; a clear takes priority over an increment.
    always_ff @(posedge AXI_ACLK) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset || cnt_clear[i])
                cnt[i] <= '0;
            else if (head_beat && M_AXIS_TUSER[SRC_PORT_POS+i] && !(&cnt[i]))
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign port_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end

endmodule
